multi_edge_detector: RTL

//  Parametrised N-channel edge detector; successor to the single-channel positive edge detector.
//  Per channel: optional input synchroniser, selectable edge mode (off/rise/fall/both), one-cycle pulse.

---
 rtl/multi_edge_detector.sv | 113 +++++++++++
 1 files changed

// File: rtl/multi_edge_detector.sv
// N-channel edge detector: per-channel synchroniser, selectable edge mode, one-cycle pulse,
// sticky flags with clear, OR'd interrupt and a saturating event counter.
module multi_edge_detector #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     a,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     clr,
  input  logic                 cnt_clr,
  output logic [WIDTH-1:0]     pulse,
  output logic [WIDTH-1:0]     sticky,
  output logic                 irq,
  output logic [CNT_W-1:0]     evt_cnt
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  // Detection stays masked until the synchroniser and prev have been refilled from real input.
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);
  localparam int SUM_W   = CNT_W + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] hit;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic [SUM_W-1:0] hit_cnt;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign d = a;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];

      // NOTE: the synchroniser is a small flop array, not a RAM; it must be reset so a stale level
      // left over from before reset can never be compared against prev and fake an edge.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
          sync_q[0] <= a;
          for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
      end

      assign d = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign armed = (arm_cnt == ARM_W'(ARM_MAX));
  assign rise  = d & ~prev;
  assign fall  = ~d & prev;

  // NOTE: every always_comb output gets a default before any branch so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (edge_mode_e'(mode[2*i +: 2]))
        MODE_RISE: hit[i] = rise[i];
        MODE_FALL: hit[i] = fall[i];
        MODE_BOTH: hit[i] = rise[i] | fall[i];
        default:   hit[i] = 1'b0;
      endcase
    end
    if (!armed) hit = '0;
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < WIDTH; i++) hit_cnt = hit_cnt + SUM_W'(hit[i]);
  end

  // One extra bit of headroom lets the sum be compared against the ceiling instead of wrapping.
  assign cnt_sum  = (cnt_clr ? '0 : {1'b0, evt_cnt}) + hit_cnt;
  assign cnt_next = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];

  // NOTE: all state updates use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev    <= '0;
      pulse   <= '0;
      sticky  <= '0;
      evt_cnt <= '0;
      arm_cnt <= '0;
    end else begin
      prev    <= d;
      pulse   <= hit;
      sticky  <= hit | (sticky & ~clr);
      evt_cnt <= cnt_next;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign irq = |sticky;

endmodule
